// File: rtl/seq_detect_param.sv
// seq_detect_param
// Runtime-programmable serial pattern detector. A pattern of 1..MAX_LEN bits
// is loaded with cfg_load; the block then watches inp_bit (qualified by
// inp_valid) and pulses seq_seen for one cycle per match. Matches can be
// overlapping or non-overlapping, and are tallied in a saturating counter.

module seq_detect_param #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               inp_valid,
    input  logic               inp_bit,
    input  logic               count_clr,
    output logic               seq_seen,
    output logic [CNT_W-1:0]   match_count,
    output logic               cfg_err
);

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

    typedef enum logic {
        UNCFG = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic [MAX_LEN-1:0] pattern_q, pattern_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               overlap_q, overlap_d;
    logic               seq_seen_d;
    logic [CNT_W-1:0]   match_count_d;
    logic               cfg_err_d;

    // Detection datapath signals
    logic               cfg_ok;
    logic               accept;
    logic [MAX_LEN-1:0] hist_n;
    logic [LEN_W-1:0]   fill_n;
    logic [MAX_LEN-1:0] len_mask;
    logic               match;
    logic [CNT_W-1:0]   count_base;

    // Candidate history/fill, length mask and match decision for the current bit
    always_comb begin
        cfg_ok   = (cfg_len != '0) && (cfg_len <= LEN_MAX);
        accept   = (state_q == RUN) && inp_valid && !cfg_load;
        hist_n   = {hist_q[MAX_LEN-2:0], inp_bit};
        fill_n   = (fill_q == LEN_MAX) ? fill_q : fill_q + LEN_W'(1);
        len_mask = '0;
        for (int unsigned i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (LEN_W'(i) < len_q);
        end
        match = accept && (fill_n >= len_q) &&
                (((hist_n ^ pattern_q) & len_mask) == '0);
    end

    // Next-state logic: configuration load, detection update and counter
    always_comb begin
        state_d       = state_q;
        hist_d        = hist_q;
        fill_d        = fill_q;
        pattern_d     = pattern_q;
        len_d         = len_q;
        overlap_d     = overlap_q;
        cfg_err_d     = cfg_err;
        seq_seen_d    = 1'b0;
        match_count_d = match_count;
        count_base    = match_count;

        if (cfg_load) begin
            // A load always restarts history; an invalid length also drops
            // the previous configuration so no stale pattern can match.
            hist_d = '0;
            fill_d = '0;
            if (cfg_ok) begin
                state_d   = RUN;
                pattern_d = cfg_pattern;
                len_d     = cfg_len;
                overlap_d = cfg_overlap;
                cfg_err_d = 1'b0;
            end else begin
                state_d   = UNCFG;
                pattern_d = '0;
                len_d     = '0;
                overlap_d = 1'b0;
                cfg_err_d = 1'b1;
            end
        end else if (accept) begin
            seq_seen_d = match;
            if (match && !overlap_q) begin
                hist_d = '0;
                fill_d = '0;
            end else begin
                hist_d = hist_n;
                fill_d = fill_n;
            end
        end

        // Clear takes effect before a same-cycle match is counted
        count_base = count_clr ? '0 : match_count;
        if (match && (count_base != '1)) begin
            match_count_d = count_base + CNT_W'(1);
        end else begin
            match_count_d = count_base;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= UNCFG;
            hist_q      <= '0;
            fill_q      <= '0;
            pattern_q   <= '0;
            len_q       <= '0;
            overlap_q   <= 1'b0;
            seq_seen    <= 1'b0;
            match_count <= '0;
            cfg_err     <= 1'b0;
        end else begin
            state_q     <= state_d;
            hist_q      <= hist_d;
            fill_q      <= fill_d;
            pattern_q   <= pattern_d;
            len_q       <= len_d;
            overlap_q   <= overlap_d;
            seq_seen    <= seq_seen_d;
            match_count <= match_count_d;
            cfg_err     <= cfg_err_d;
        end
    end

endmodule

// File: tb/tb_seq_detect_param.sv
// Testbench for seq_detect_param: directed scenarios plus a long pseudo-random
// stream checked against a queue-based reference. Stimulus pushes the expected
// post-edge outputs into a scoreboard; a monitor pops one entry per cycle.

module tb_seq_detect_param;

    logic       clk;
    logic       reset;
    logic       cfg_load;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;
    logic       cfg_overlap;
    logic       inp_valid;
    logic       inp_bit;
    logic       count_clr;

    logic       seen8, err8;
    logic [7:0] cnt8;
    logic       seen2, err2;
    logic [1:0] cnt2;

    seq_detect_param #(.MAX_LEN(8), .LEN_W(4), .CNT_W(8)) dut8 (
        .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .inp_valid(inp_valid),
        .inp_bit(inp_bit), .count_clr(count_clr), .seq_seen(seen8),
        .match_count(cnt8), .cfg_err(err8)
    );

    seq_detect_param #(.MAX_LEN(8), .LEN_W(4), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .inp_valid(inp_valid),
        .inp_bit(inp_bit), .count_clr(count_clr), .seq_seen(seen2),
        .match_count(cnt2), .cfg_err(err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         seen;
        bit         err;
        logic [7:0] c8;
        logic [1:0] c2;
        string      nm;
    } exp_t;

    exp_t sb[$];
    int   vectors    = 0;
    int   miscompares = 0;

    // Expected counters and error flag tracked alongside the stimulus
    logic [7:0] m_c8 = 8'd0;
    logic [1:0] m_c2 = 2'd0;
    bit         m_err = 1'b0;

    // Reference detector for the random phase
    bit         hq[$];
    logic [7:0] r_pat;
    int         r_len;
    bit         r_ov;

    // Monitor: one expectation per driven cycle, sampled 1 time unit after the edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                vectors++;
                if (seen8 !== e.seen || seen2 !== e.seen || err8 !== e.err ||
                    err2 !== e.err || cnt8 !== e.c8 || cnt2 !== e.c2) begin
                    miscompares++;
                    $display("FAIL %s: got seen=%b/%b err=%b/%b cnt8=%0d cnt2=%0d, expected seen=%b err=%b cnt8=%0d cnt2=%0d",
                             e.nm, seen8, seen2, err8, err2, cnt8, cnt2,
                             e.seen, e.err, e.c8, e.c2);
                end
            end
        end
    end

    task automatic drive(input bit rst, input bit ld, input logic [7:0] pat,
                         input logic [3:0] ln, input bit ov, input bit v,
                         input bit b, input bit clr, input bit e_seen,
                         input string nm);
        exp_t e;
        @(negedge clk);
        reset       = rst;
        cfg_load    = ld;
        cfg_pattern = pat;
        cfg_len     = ln;
        cfg_overlap = ov;
        inp_valid   = v;
        inp_bit     = b;
        count_clr   = clr;
        if (rst) begin
            m_c8  = 8'd0;
            m_c2  = 2'd0;
            m_err = 1'b0;
        end else begin
            if (clr) begin
                m_c8 = 8'd0;
                m_c2 = 2'd0;
            end
            if (e_seen) begin
                if (m_c8 != 8'hFF) m_c8 = m_c8 + 8'd1;
                if (m_c2 != 2'b11) m_c2 = m_c2 + 2'd1;
            end
        end
        e.seen = e_seen;
        e.err  = m_err;
        e.c8   = m_c8;
        e.c2   = m_c2;
        e.nm   = nm;
        sb.push_back(e);
    endtask

    task automatic rst_cyc(input string nm);
        drive(1, 0, 8'h00, 4'd0, 0, 0, 0, 0, 0, nm);
    endtask

    // Load with a valid '1' on inp_bit in the same cycle; that bit must be dropped
    task automatic load(input logic [7:0] pat, input logic [3:0] ln, input bit ov,
                        input string nm);
        m_err = !((ln >= 4'd1) && (ln <= 4'd8));
        r_pat = pat;
        r_len = int'(ln);
        r_ov  = ov;
        hq.delete();
        drive(0, 1, pat, ln, ov, 1, 1, 0, 0, nm);
    endtask

    task automatic bitv(input bit v, input bit b, input bit clr, input bit e_seen,
                        input string nm);
        drive(0, 0, 8'h00, 4'd0, 0, v, b, clr, e_seen, nm);
    endtask

    task automatic idle(input int n, input string nm);
        for (int i = 0; i < n; i++) bitv(0, 0, 0, 0, nm);
    endtask

    task automatic stream(input string bits, input string hits, input string nm);
        for (int i = 0; i < bits.len(); i++) begin
            bitv(1, bits[i] == "1", 0, hits[i] == "1", nm);
        end
    endtask

    function automatic bit ref_step(input bit b);
        bit m;
        hq.push_back(b);
        if (hq.size() > 8) void'(hq.pop_front());
        m = (hq.size() >= r_len);
        if (m) begin
            for (int k = 0; k < r_len; k++) begin
                if (hq[hq.size() - r_len + k] != r_pat[r_len - 1 - k]) m = 1'b0;
            end
        end
        if (m && !r_ov) hq.delete();
        return m;
    endfunction

    initial begin
        reset = 1'b1; cfg_load = 1'b0; cfg_pattern = '0; cfg_len = '0;
        cfg_overlap = 1'b0; inp_valid = 1'b0; inp_bit = 1'b0; count_clr = 1'b0;

        rst_cyc("reset0");
        rst_cyc("reset1");

        // 1: overlapping 1011
        load(8'b0000_1011, 4'd4, 1, "t1_load");
        stream("1011011", "0001001", "t1_ovl");
        idle(1, "t1_tail");

        // 2: non-overlapping 1011
        load(8'b0000_1011, 4'd4, 0, "t2_load");
        stream("1011011", "0001000", "t2_novl");
        idle(1, "t2_tail");

        // 3: invalid lengths, then a valid 2-bit pattern
        load(8'h0F, 4'd0, 1, "t3_len0");
        load(8'h0F, 4'd9, 1, "t3_len9");
        stream("1111", "0000", "t3_uncfg");
        load(8'b0000_0011, 4'd2, 1, "t3_len2");
        stream("111", "011", "t3_run");
        idle(1, "t3_tail");

        // 4: counter saturation (CNT_W=2) and clear
        bitv(0, 0, 1, 0, "t4_clr_alone");
        load(8'b0000_0001, 4'd1, 1, "t4_load");
        stream("11111", "11111", "t4_sat");
        bitv(1, 1, 1, 1, "t4_clr_match");
        idle(1, "t4_tail");

        // 5: gaps do not break a pattern; reset mid-pattern does
        load(8'b0000_0101, 4'd3, 1, "t5_load");
        stream("10", "00", "t5_pre");
        idle(5, "t5_gap");
        stream("1", "1", "t5_done");
        idle(1, "t5_tail");
        load(8'b0000_0101, 4'd3, 1, "t5_reload");
        stream("10", "00", "t5_pre2");
        rst_cyc("t5_reset");
        stream("101", "000", "t5_after_rst");

        // 6: long random streams against the reference, both overlap modes
        for (int ov = 1; ov >= 0; ov--) begin
            load(8'b1011_0011, 4'd8, ov[0], "t6_load");
            for (int i = 0; i < 2000; i++) begin
                bit v, b, m;
                v = ($urandom_range(3) != 0);
                b = $urandom_range(1);
                m = v ? ref_step(b) : 1'b0;
                bitv(v, b, 0, m, ov ? "t6_rand_ovl" : "t6_rand_novl");
            end
            idle(1, "t6_tail");
        end

        repeat (3) @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
